vec_sqr_sum_seq: RTL and testbench

VEC_SQR_SUM_SEQ -- requirements
Module: vec_sqr_sum_seq

---
 rtl/vec_sqr_sum_seq_pkg.sv | 26 ++
 rtl/fxp_round_sat.sv | 36 +++
 rtl/vec_sqr_sum_seq.sv | 151 +++++++++++++++
 tb/tb_vec_sqr_sum_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_sqr_sum_seq_pkg.sv
// Shared types and constants for the vector sum-of-squares block:
// FSM state encoding plus saturation and rounding constant helpers.
package vec_sqr_sum_seq_pkg;

  localparam int MAX_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Largest positive value of an n-bit signed number, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_max_f(input int n);
    logic [MAX_W-1:0] one_v;
    one_v = {{(MAX_W-1){1'b0}}, 1'b1};
    return (one_v << (n - 1)) - one_v;
  endfunction

  function automatic logic [MAX_W-1:0] rnd_const_f(input int frac_w);
    logic [MAX_W-1:0] one_v;
    one_v = {{(MAX_W-1){1'b0}}, 1'b1};
    return one_v << (frac_w - 1);
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Rescales the unsigned 2*FRAC_WIDTH-fraction accumulator to FRAC_WIDTH
// fraction bits with round-half-up, then saturates to the N-bit signed maximum.
module fxp_round_sat
  import vec_sqr_sum_seq_pkg::*;
#(
  parameter int N          = 32,
  parameter int FRAC_WIDTH = 30,
  parameter int AW         = 66
) (
  input  logic [AW-1:0] acc_i,
  output logic [N-1:0]  res_o,
  output logic          ovf_o
);

  // One spare bit so adding the rounding constant can never wrap.
  localparam int RW = AW + 1;
  localparam logic [RW-1:0] RND_C = RW'(rnd_const_f(FRAC_WIDTH));
  localparam logic [RW-1:0] MAX_C = RW'(sat_max_f(N));

  logic [RW-1:0] rounded_s;
  logic [RW-1:0] shifted_s;

  // Round, shift and clamp.
  always_comb begin
    rounded_s = {1'b0, acc_i} + RND_C;
    shifted_s = rounded_s >> FRAC_WIDTH;
    if (shifted_s > MAX_C) begin
      res_o = MAX_C[N-1:0];
      ovf_o = 1'b1;
    end else begin
      res_o = shifted_s[N-1:0];
      ovf_o = 1'b0;
    end
  end

endmodule

// File: rtl/vec_sqr_sum_seq.sv
// Sequential sum of squares of a DIM-component signed fixed-point vector,
// one component per cycle through a single shared multiplier.
module vec_sqr_sum_seq
  import vec_sqr_sum_seq_pkg::*;
#(
  parameter int N          = 32,
  parameter int FRAC_WIDTH = 30,
  parameter int DIM        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIM*N-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     sum,
  output logic             ovf
);

  localparam int AW = 2 * N + $clog2(DIM + 1);
  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;

  state_e                  state_q, state_d;
  logic [DIM*N-1:0]        vec_q, vec_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [N-1:0]            sum_q, sum_d;
  logic                    ovf_q, ovf_d;

  logic [N-1:0]            comp_s;
  logic signed [2*N-1:0]   ext_s;
  logic signed [2*N-1:0]   prod_s;
  logic [AW-1:0]           acc_nxt_s;
  logic                    last_s;
  logic [N-1:0]            res_s;
  logic                    res_ovf_s;

  // Square the current component; sign extension first keeps -2^(N-1) exact.
  always_comb begin
    comp_s    = vec_q[int'(idx_q)*N +: N];
    ext_s     = {{N{comp_s[N-1]}}, comp_s};
    prod_s    = ext_s * ext_s;
    acc_nxt_s = acc_q + {{(AW-2*N){1'b0}}, prod_s};
    last_s    = (idx_q == IW'(DIM - 1));
  end

  fxp_round_sat #(
    .N          (N),
    .FRAC_WIDTH (FRAC_WIDTH),
    .AW         (AW)
  ) u_round_sat (
    .acc_i (acc_nxt_s),
    .res_o (res_s),
    .ovf_o (res_ovf_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_MAC;
        else          state_d = ST_IDLE;
      end
      ST_MAC: begin
        if (last_s) state_d = ST_DONE;
        else        state_d = ST_MAC;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
        else           state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      ST_MAC:  in_ready  = 1'b0;
      default: in_ready  = 1'b1;
    endcase
  end

  // Datapath next-state: latch on accept, accumulate in MAC, capture result on last add.
  always_comb begin
    vec_d = vec_q;
    idx_d = idx_q;
    acc_d = acc_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          vec_d = in_vec;
          idx_d = '0;
          acc_d = '0;
        end else begin
          vec_d = vec_q;
        end
      end
      ST_MAC: begin
        acc_d = acc_nxt_s;
        idx_d = idx_q + IW'(1);
        if (last_s) begin
          sum_d = res_s;
          ovf_d = res_ovf_s;
        end else begin
          sum_d = sum_q;
        end
      end
      ST_DONE: vec_d = vec_q;
      default: vec_d = vec_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vec_q <= vec_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum = sum_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_vec_sqr_sum_seq.sv
// Randomized self-checking bench for vec_sqr_sum_seq with a behavioural
// sum-of-squares model, a per-cycle scoreboard and directed corner cases.
module tb_vec_sqr_sum_seq;

  localparam int N   = 32;
  localparam int FW  = 30;
  localparam int DIM = 3;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DIM*N-1:0] in_vec;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    sum;
  logic            ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit rand_rdy  = 1'b0;
  bit rdy_force = 1'b1;

  typedef struct {
    logic [N-1:0] s;
    logic         o;
    int           acc;
  } exp_t;
  exp_t exp_q[$];
  bit   head_seen = 1'b0;

  vec_sqr_sum_seq #(.N(N), .FRAC_WIDTH(FW), .DIM(DIM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    else          out_ready = rdy_force;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Real-valued meaning: sum of squares of Q(FW) numbers, rounded half-up, clamped.
  function automatic logic [N:0] model(input logic [DIM*N-1:0] v);
    logic [127:0] acc;
    logic [127:0] r;
    longint       c;
    logic [63:0]  p;
    acc = '0;
    for (int k = 0; k < DIM; k++) begin
      c   = longint'($signed(v[k*N +: N]));
      p   = 64'(c * c);
      acc = acc + {64'd0, p};
    end
    r = (acc + (128'd1 << (FW - 1))) >> FW;
    if (r > 128'h7FFF_FFFF) return {1'b1, 32'h7FFF_FFFF};
    return {1'b0, r[N-1:0]};
  endfunction

  // Scoreboard: checks every cycle the outputs carry meaning.
  always @(negedge clk) begin
    logic [N:0] m;
    if (!rst_n) begin
      chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
      chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
      chk("rst_sum", 64'(sum), 64'(32'h0));
      chk("rst_ovf", 64'(ovf), 64'(1'b0));
      exp_q.delete();
      head_seen = 1'b0;
    end else begin
      if (exp_q.size() > 0) chk("busy_in_ready", 64'(in_ready), 64'(1'b0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 64'(out_valid), 64'(1'b0));
        end else begin
          if (!head_seen) begin
            chk("latency", 64'(cyc - exp_q[0].acc), 64'(DIM));
            head_seen = 1'b1;
          end
          chk("sum", 64'(sum), 64'(exp_q[0].s));
          chk("ovf", 64'(ovf), 64'(exp_q[0].o));
          if (out_ready) begin
            void'(exp_q.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        m = model(in_vec);
        exp_q.push_back('{s: m[N-1:0], o: m[N], acc: cyc + 1});
      end
    end
  end

  task automatic send(input logic [DIM*N-1:0] v);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_vec   = v;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec   = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_valid(output logic [N-1:0] s, output logic o);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("result_timeout", 64'(out_valid), 64'(1'b1));
    s = sum;
    o = ovf;
  endtask

  task automatic directed(input string nm, input logic [DIM*N-1:0] v,
                          input logic [N-1:0] es, input logic eo);
    logic [N-1:0] s;
    logic         o;
    send(v);
    wait_valid(s, o);
    chk({nm, "_sum"}, 64'(s), 64'(es));
    chk({nm, "_ovf"}, 64'(o), 64'(eo));
  endtask

  initial begin
    logic [N-1:0]     s0;
    logic             o0;
    logic [DIM*N-1:0] v;
    logic [N-1:0]     cv;
    int               n;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_vec   = '0;
    out_ready = 1'b1;

    // Literal pins on the model itself.
    chk("pin_model_075", 64'(model({3{32'h2000_0000}})), 64'({1'b0, 32'h3000_0000}));
    chk("pin_model_sat", 64'(model({32'h0, 32'h0, 32'h8000_0000})), 64'({1'b1, 32'h7FFF_FFFF}));
    chk("pin_model_rnd", 64'(model({32'h0, 32'h0, 32'h0000_4000})), 64'({1'b0, 32'h0}));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    directed("p075",   {3{32'h2000_0000}},               32'h3000_0000, 1'b0);
    directed("p3sat",  {3{32'h4000_0000}},               32'h7FFF_FFFF, 1'b1);
    directed("neg1",   {32'h0, 32'h0, 32'hC000_0000},    32'h4000_0000, 1'b0);
    directed("rndup",  {3{32'h0000_4000}},               32'h0000_0001, 1'b0);
    directed("rnddn",  {32'h0, 32'h0, 32'h0000_4000},    32'h0000_0000, 1'b0);
    directed("minneg", {32'h0, 32'h0, 32'h8000_0000},    32'h7FFF_FFFF, 1'b1);

    // Back-pressure: hold the result for 10 cycles, poke in_valid meanwhile.
    @(posedge clk); #1 rdy_force = 1'b0;
    send({32'h1000_0000, 32'hF000_0000, 32'h2000_0000});
    wait_valid(s0, o0);
    chk("stall_first", 64'(s0), 64'(32'h1800_0000));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_vec   = {$urandom, $urandom, $urandom};
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'(1'b1));
      chk("stall_sum", 64'(sum), 64'(s0));
      chk("stall_ovf", 64'(ovf), 64'(o0));
      chk("stall_in_ready", 64'(in_ready), 64'(1'b0));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    rdy_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_idle", 64'(in_ready), 64'(1'b1));
    chk("release_valid", 64'(out_valid), 64'(1'b0));

    // Asynchronous reset in the second MAC cycle aborts the operation.
    send({3{32'h3000_0000}});
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'(1'b0));
    chk("abort_in_ready", 64'(in_ready), 64'(1'b1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    directed("post_rst", {3{32'h2000_0000}}, 32'h3000_0000, 1'b0);

    // Randomized traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < DIM; k++) begin
        case ($urandom_range(0, 4))
          0:       cv = $urandom;
          1:       cv = 32'($signed(16'($urandom)));
          2:       cv = 32'h8000_0000;
          3:       cv = 32'($signed(31'($urandom)));
          default: cv = 32'h0;
        endcase
        v[k*N +: N] = cv;
      end
      send(v);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    rand_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
